led_bar_arbiter: RTL
====================

Name: led_bar_arbiter

Overview:
Shares the 8-LED cathode bar (`cats`) between up to NUM_REQ challenge/pattern sources.
- Round-robin arbitration with a minimum dwell time per grant.
- One blanking cycle between owners.
- Applies global PWM brightness to the granted pattern.
- Sits between the challenge modules (each drives a pattern and a request) and the top-level `cats` pins, replacing the per-challenge PWM gating.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DWELL_CYCLES, 24_000_000: minimum grant hold in clk cycles (0.5 s at 48 MHz); must be >= 1.
- PWM_BITS, 3: PWM counter width; PWM period = 2^PWM_BITS cycles.

Ports:
- clk  input  1  system clock (48 MHz).
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- req  input  NUM_REQ  request bit per source; level-sensitive, held while the source wants the bar.
- pattern  input  8*NUM_REQ  source i pattern in bits [8*i+7:8*i].
- duty  input  PWM_BITS  brightness; LEDs on while pwm_cnt < duty (0 = dark, max = (2^PWM_BITS-1)/2^PWM_BITS).
- grant  output  NUM_REQ  one-hot owner, or all zero.
- busy  output  1  high while in HOLD.
- cats  output  8  LED cathode drive.

Behaviour:
- Reset (rst_n low at a posedge):
  - state=IDLE; grant=0, busy=0, cats=0.
  - pwm_cnt=0, dwell_cnt=0.
  - last_owner=NUM_REQ-1, so the first arbitration favours index 0.
  - Reset mid-HOLD drops the grant on that same edge; no blanking cycle is needed.
- pwm_cnt: free-running, increments every cycle, wraps from 2^PWM_BITS-1 to 0. pwm_on = (pwm_cnt < duty), unsigned compare.
- States: IDLE, HOLD, ARB.
- IDLE:
  - grant=0, cats=0.
  - If any req bit is high at edge t, select the first set bit searching last_owner+1, last_owner+2, ... modulo NUM_REQ.
  - At t+1: grant = that bit, state=HOLD, dwell_cnt=0, last_owner=index.
- HOLD:
  - busy=1; dwell_cnt increments, saturating at DWELL_CYCLES-1.
  - dwell_done = (dwell_cnt == DWELL_CYCLES-1).
  - Exit rules, evaluated each edge in this priority:
    1. Owner's req low -> ARB.
    2. dwell_done and any other req high -> ARB.
    3. Otherwise stay; the owner keeps the bar indefinitely while alone.
- ARB (exactly 1 cycle):
  - grant=0, busy=0, cats=0 (blanking).
  - Next edge: if any req high, round-robin select from last_owner+1 -> HOLD, dwell_cnt=0; else -> IDLE.
  - A re-requesting previous owner is chosen only if no other req is high.
- cats: registered.
  - In HOLD: cats(t+1) = pattern[owner](t) & {8{pwm_on(t)}}.
  - Otherwise cats(t+1)=0.
  - Latency from a grant edge to the first visible pattern is 1 cycle.
  - Pattern changes from the owner are shown live, 1 cycle late.
- Boundaries:
  - Simultaneous requests are resolved by round-robin order only.
  - req deasserting and another asserting on the same edge: rule 1 applies; the new source wins in the following ARB.
  - A req pulse shorter than 1 cycle while in HOLD is not remembered.
  - DWELL_CYCLES=1: dwell_done from the first HOLD cycle.
  - duty changes take effect on the next cycle.

Optional Feature:
- Macro: LED_ARB_PREEMPT_EN.
- Defined: requester 0 is urgent. If req[0] is high in HOLD while owner != 0, exit to ARB regardless of dwell_done. ARB then grants index 0, overriding round-robin. last_owner is updated to 0 as usual.
- Undefined: req[0] has no special treatment; pure round-robin with dwell.

Test Plan:
- Reset and idle: rst_n=0 for 3 cycles with req=4'b1111 -> grant=0, cats=0, busy=0. Release reset -> grant=4'b0001 one cycle later, busy=1.
- Single owner, PWM: NUM_REQ=4, DWELL_CYCLES=8, PWM_BITS=3, req=4'b0010, pattern[1]=8'hA5, duty=3 -> grant=4'b0010 held forever. cats=8'hA5 for 3 of every 8 cycles and 0 otherwise. duty=0 -> cats stays 0.
- Rotation: req=4'b0101 constant, DWELL_CYCLES=8 -> grant sequence 0001 (8 cycles), 0000 (1 cycle), 0100 (8 cycles), 0000, 0001, ... cats=0 during every blank cycle.
- Early release: owner 2 drops req after 3 HOLD cycles while req[3]=1 -> next cycle grant=0; the cycle after, grant=4'b1000 and dwell restarts.
- Reset mid-HOLD: rst_n=0 during HOLD at dwell_cnt=5 -> grant=0, cats=0 on that edge. After release with req=4'b1111 -> index 0 granted first.
- Preempt (LED_ARB_PREEMPT_EN defined): owner 2 in HOLD at dwell_cnt=2, req[0] rises -> 1 blank cycle, then grant=4'b0001. With the macro undefined, owner 2 holds until dwell_done.

Source files
------------

// File: rtl/led_bar_arbiter_if.sv
// Bundles the request, pattern, duty and LED-drive signals between the
// challenge sources (master) and led_bar_arbiter (slave).
interface led_bar_arbiter_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned PWM_BITS = 3
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] pattern;
    logic [PWM_BITS-1:0]  duty;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic [7:0]           cats;

    modport master (
        output req, pattern, duty,
        input  grant, busy, cats
    );

    modport slave (
        input  req, pattern, duty,
        output grant, busy, cats
    );
endinterface

// File: rtl/led_bar_arbiter.sv
// Round-robin owner of the 8-LED cathode bar with minimum dwell, one blanking
// cycle between owners and global PWM. Optional urgent requester 0: LED_ARB_PREEMPT_EN.
module led_bar_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DWELL_CYCLES = 24_000_000,
    parameter int unsigned PWM_BITS     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    led_bar_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        ARB
    } state_t;

    state_t               state, state_next;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [DW_W-1:0]      dwell_cnt;
    logic [IDX_W-1:0]     last_owner;
    logic [7:0]           cats_q;

    logic                 pwm_on;
    logic                 dwell_done;
    logic [NUM_REQ-1:0]   owner_mask;
    logic                 owner_req;
    logic                 other_req;
    logic                 preempt;
    logic                 urgent;
    logic                 rr_any;
    logic [IDX_W-1:0]     rr_idx;
    int unsigned          cand;
    logic [IDX_W-1:0]     cand_idx;
    logic                 sel_load;
    logic [IDX_W-1:0]     sel_idx;

    // last_owner doubles as the current owner while in HOLD
    assign pwm_on     = (pwm_cnt < bus.duty);
    assign dwell_done = (dwell_cnt == DWELL_MAX);
    assign owner_mask = NUM_REQ'(1) << last_owner;
    assign owner_req  = bus.req[last_owner];
    assign other_req  = |(bus.req & ~owner_mask);

`ifdef LED_ARB_PREEMPT_EN
    assign urgent  = bus.req[0];
    assign preempt = bus.req[0] && (last_owner != '0);
`else
    assign urgent  = 1'b0;
    assign preempt = 1'b0;
`endif

    // First set request searching last_owner+1, last_owner+2, ... modulo NUM_REQ
    always_comb begin
        rr_any   = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(last_owner) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!rr_any && bus.req[cand_idx]) begin
                rr_any = 1'b1;
                rr_idx = cand_idx;
            end
        end
    end

    always_comb begin
        state_next = state;
        sel_load   = 1'b0;
        sel_idx    = rr_idx;
        case (state)
            IDLE: begin
                if (rr_any) begin
                    state_next = HOLD;
                    sel_load   = 1'b1;
                end
            end
            HOLD: begin
                if (!owner_req || preempt || (dwell_done && other_req)) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                if (urgent) begin
                    state_next = HOLD;
                    sel_load   = 1'b1;
                    sel_idx    = '0;
                end else if (rr_any) begin
                    state_next = HOLD;
                    sel_load   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pwm_cnt    <= '0;
            dwell_cnt  <= '0;
            last_owner <= LAST_IDX;
            cats_q     <= '0;
        end else begin
            state   <= state_next;
            pwm_cnt <= pwm_cnt + 1'b1;
            if (sel_load) begin
                last_owner <= sel_idx;
                dwell_cnt  <= '0;
            end else if (state == HOLD && !dwell_done) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
            // Gating on state_next as well keeps the bar dark during the ARB blank cycle
            if (state == HOLD && state_next == HOLD) begin
                cats_q <= bus.pattern[{last_owner, 3'b000} +: 8] & {8{pwm_on}};
            end else begin
                cats_q <= '0;
            end
        end
    end

    assign bus.grant = (state == HOLD) ? owner_mask : '0;
    assign bus.busy  = (state == HOLD);
    assign bus.cats  = cats_q;
endmodule
